fwd_hazard_ctrl: RTL

//  Parametrised forwarding and load-use hazard controller for the 5-stage pipeline. Generalises
//  EX-stage forwarding to NSRC source operands and AW-bit register addresses. Adds a load-use stall FSM

---
 rtl/fwd_hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding-select and load-use hazard controller for the 5-stage pipeline.
//   Picks the EX operand source for each of NSRC source operands and stalls
//   IF/ID and bubbles ID/EX for LD_LAT cycles when an ID instruction reads a
//   register that the load currently in EX will write.
//
// Parameters
//   AW      register address width
//   NSRC    source operands per instruction (src k at bits [k*AW +: AW])
//   LD_LAT  bubbles inserted per load-use hazard (>= 1)
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   pipe_hold                  global freeze: FSM and counter hold state
//   flush                      cancels any pending/active stall
//   id_valid, id_src,
//   id_src_used                ID-stage instruction and its source operands
//   idex_src, idex_rd,
//   idex_regwrite,
//   idex_memread               EX-stage operands / destination / type
//   exmem_*, memwb_*           MEM and WB stage destination / type
//   fwd_sel                    per-source select, bits [2k+1:2k]:
//                              00 regfile, 01 MEM/WB ALU, 10 EX/MEM ALU,
//                              11 MEM/WB load data
//   stall_if, bubble_idex      hold PC + IF/ID, insert NOP into ID/EX
//   stall_cnt                  saturating count of stalled cycles
//
// Build option
//   FWD_ZERO_REG_EN  when defined, r0 is hardwired zero: no register match
//                    against r0 ever forwards or stalls.
module fwd_hazard_ctrl #(
    parameter int AW     = 3,
    parameter int NSRC   = 2,
    parameter int LD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [NSRC*AW-1:0]   idex_src,
    input  logic [AW-1:0]        idex_rd,
    input  logic                 idex_regwrite,
    input  logic                 idex_memread,
    input  logic [AW-1:0]        exmem_rd,
    input  logic                 exmem_regwrite,
    input  logic                 exmem_memread,
    input  logic [AW-1:0]        memwb_rd,
    input  logic                 memwb_regwrite,
    input  logic                 memwb_memread,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall_if,
    output logic                 bubble_idex,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int REM_W = $clog2(LD_LAT + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LD_LAT - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] STALL = 2'b01;

    logic [1:0]       state, stateNext;
    logic [REM_W-1:0] rem, remNext;
    logic [CNT_W-1:0] stallCnt;
    logic             hz;
    logic             stallRaw;

    // Register-number compare; r0 never matches when it is hardwired zero.
    function automatic logic regMatch(input logic [AW-1:0] rd, input logic [AW-1:0] src);
`ifdef FWD_ZERO_REG_EN
        return (rd == src) && (rd != '0);
`else
        return (rd == src);
`endif
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // Forward select: newest producer wins. A load sitting in EX/MEM is never
    // forwarded; the stall guarantees its consumer is not in EX yet.
    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (exmem_regwrite && !exmem_memread && regMatch(exmem_rd, idex_src[k*AW +: AW]))
                fwd_sel[2*k +: 2] = 2'b10;
            else if (memwb_regwrite && memwb_memread && regMatch(memwb_rd, idex_src[k*AW +: AW]))
                fwd_sel[2*k +: 2] = 2'b11;
            else if (memwb_regwrite && !memwb_memread && regMatch(memwb_rd, idex_src[k*AW +: AW]))
                fwd_sel[2*k +: 2] = 2'b01;
        end
    end

    // Load-use hazard: a used ID source matches the load destination in EX.
    always_comb begin
        hz = 1'b0;
        for (int k = 0; k < NSRC; k++)
            hz = hz | (id_src_used[k] && regMatch(idex_rd, id_src[k*AW +: AW]));
        hz = hz && id_valid && idex_memread && idex_regwrite;
    end

    // The first bubble is raised combinationally from IDLE; STALL supplies the
    // remaining LD_LAT-1 without looking at hz, since the load has left EX.
    assign stallRaw    = !flush && ((state == STALL) || ((state == IDLE) && hz));
    assign stall_if    = rst_n && stallRaw;
    assign bubble_idex = rst_n && stallRaw;
    assign stall_cnt   = stallCnt;

    always_comb begin
        stateNext = state;
        remNext   = rem;
        if (flush) begin
            stateNext = IDLE;
            remNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz && (LD_LAT > 1)) begin
                        stateNext = STALL;
                        remNext   = REM_INIT;
                    end
                end
                STALL: begin
                    if (rem == REM_ONE) begin
                        stateNext = IDLE;
                        remNext   = '0;
                    end else begin
                        remNext = rem - REM_ONE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    remNext   = '0;
                end
            endcase
        end
    end

    // Control state; everything freezes while the pipeline is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            stallCnt <= '0;
        end else if (!pipe_hold) begin
            state <= stateNext;
            rem   <= remNext;
            if (stallRaw)
                stallCnt <= satInc(stallCnt);
        end
    end

endmodule
